// File: rtl/lcd_bus_sequencer.sv
// Write-only 8080-style parallel LCD bus sequencer: buffers command/data words in a FIFO,
// generates csx/dcx/wrx timing and runs the panel hardware-reset sequence.
module lcd_bus_sequencer #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned WR_LOW_CYC   = 2,
  parameter int unsigned WR_HIGH_CYC  = 2,
  parameter int unsigned RST_LOW_CYC  = 500,
  parameter int unsigned RST_WAIT_CYC = 6000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_dc,
  input  logic                          in_last,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          init_start,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          csx,
  output logic                          dcx,
  output logic                          wrx,
  output logic                          rdx,
  output logic                          lcd_reset,
  output logic [DATA_W-1:0]             data_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_W + 2;

  localparam logic [AW:0]   FullLvl    = (AW+1)'(FIFO_DEPTH);
  localparam logic [23:0]   RstLowLd   = 24'(RST_LOW_CYC - 1);
  localparam logic [23:0]   RstWaitLd  = 24'(RST_WAIT_CYC - 1);
  localparam logic [23:0]   WrLowLd    = 24'(WR_LOW_CYC - 1);
  localparam logic [23:0]   WrHighLd   = 24'(WR_HIGH_CYC - 1);

  typedef enum logic [2:0] {
    StRstLow,
    StRstWait,
    StIdle,
    StSetup,
    StWrLow,
    StWrHigh,
    StHold,
    StCsRel
  } state_e;

  // FIFO storage: entry = {last, dc, data}
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [EW-1:0] head;

  state_e              state_q, state_d;
  logic [23:0]         cnt_q, cnt_d;
  logic                csx_q, csx_d;
  logic                dcx_q, dcx_d;
  logic                wrx_q, wrx_d;
  logic                lcd_reset_q, lcd_reset_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   data_q, data_d;

  assign in_ready   = (level_q != FullLvl);
  assign push       = in_valid & in_ready;
  assign fifo_empty = (level_q == '0);
  assign head       = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {in_last, in_dc, in_data};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csx_d       = csx_q;
    dcx_d       = dcx_q;
    wrx_d       = wrx_q;
    lcd_reset_d = lcd_reset_q;
    last_d      = last_q;
    data_d      = data_q;
    pop         = 1'b0;

    unique case (state_q)
      StRstLow: begin
        if (cnt_q == '0) begin
          state_d     = StRstWait;
          cnt_d       = RstWaitLd;
          lcd_reset_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      StRstWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      StIdle: begin
        // Reset request wins over a pending word.
        if (init_start) begin
          state_d     = StRstLow;
          cnt_d       = RstLowLd;
          lcd_reset_d = 1'b0;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          last_d  = head[DATA_W+1];
          dcx_d   = head[DATA_W];
          data_d  = head[DATA_W-1:0];
          csx_d   = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        state_d = StWrLow;
        wrx_d   = 1'b0;
        cnt_d   = WrLowLd;
      end
      StWrLow: begin
        if (cnt_q == '0) begin
          state_d = StWrHigh;
          wrx_d   = 1'b1;
          cnt_d   = WrHighLd;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      StWrHigh: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 24'd1;
        end else if (last_q) begin
          state_d = StCsRel;
          csx_d   = 1'b1;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          last_d  = head[DATA_W+1];
          dcx_d   = head[DATA_W];
          data_d  = head[DATA_W-1:0];
          wrx_d   = 1'b0;
          cnt_d   = WrLowLd;
          state_d = StWrLow;
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        // Chip select stays asserted while waiting for the rest of the transfer.
        if (!fifo_empty) begin
          pop     = 1'b1;
          last_d  = head[DATA_W+1];
          dcx_d   = head[DATA_W];
          data_d  = head[DATA_W-1:0];
          wrx_d   = 1'b0;
          cnt_d   = WrLowLd;
          state_d = StWrLow;
        end
      end
      StCsRel: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRstLow;
      cnt_q       <= RstLowLd;
      csx_q       <= 1'b1;
      dcx_q       <= 1'b1;
      wrx_q       <= 1'b1;
      lcd_reset_q <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csx_q       <= csx_d;
      dcx_q       <= dcx_d;
      wrx_q       <= wrx_d;
      lcd_reset_q <= lcd_reset_d;
      last_q      <= last_d;
      data_q      <= data_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
    end
  end

  assign busy       = !((state_q == StIdle) && fifo_empty);
  assign fifo_level = level_q;
  assign csx        = csx_q;
  assign dcx        = dcx_q;
  assign wrx        = wrx_q;
  assign rdx        = 1'b1;
  assign lcd_reset  = lcd_reset_q;
  assign data_out   = data_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Self-checking bench for lcd_bus_sequencer: a negedge bus monitor captures every panel write
// and compares it in order against the words offered to the FIFO.
module tb_lcd_bus_sequencer;

  localparam int unsigned DATA_W       = 16;
  localparam int unsigned FIFO_DEPTH   = 16;
  localparam int unsigned WR_LOW_CYC   = 2;
  localparam int unsigned WR_HIGH_CYC  = 2;
  localparam int unsigned RST_LOW_CYC  = 10;
  localparam int unsigned RST_WAIT_CYC = 20;

  logic                         clk;
  logic                         reset_n;
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_dc;
  logic                         in_last;
  logic [DATA_W-1:0]            in_data;
  logic                         init_start;
  logic                         busy;
  logic [$clog2(FIFO_DEPTH):0]  fifo_level;
  logic                         csx;
  logic                         dcx;
  logic                         wrx;
  logic                         rdx;
  logic                         lcd_reset;
  logic [DATA_W-1:0]            data_out;

  lcd_bus_sequencer #(
    .DATA_W       (DATA_W),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .WR_LOW_CYC   (WR_LOW_CYC),
    .WR_HIGH_CYC  (WR_HIGH_CYC),
    .RST_LOW_CYC  (RST_LOW_CYC),
    .RST_WAIT_CYC (RST_WAIT_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dc      (in_dc),
    .in_last    (in_last),
    .in_data    (in_data),
    .init_start (init_start),
    .busy       (busy),
    .fifo_level (fifo_level),
    .csx        (csx),
    .dcx        (dcx),
    .wrx        (wrx),
    .rdx        (rdx),
    .lcd_reset  (lcd_reset),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: words the panel must see, in order ({last, dc, data}).
  logic [17:0] exp_q [$];
  // Observed: {dc, data} sampled at each wrx rising edge.
  logic [16:0] got_q [$];
  int          rise_t [$];
  int          cyc        = 0;
  int          low_cnt    = 0;
  int          cs_rise    = 0;
  int          cs_low_cnt = 0;
  logic        prev_wrx   = 1'b1;
  logic        prev_csx   = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_wrx = 1'b1;
      prev_csx = 1'b1;
      low_cnt  = 0;
    end else begin
      if (!wrx) low_cnt++;
      if (!csx) cs_low_cnt++;
      if (wrx && !prev_wrx) begin
        check_eq("csx_at_write", 32'(csx), 32'd0);
        check_eq("wrx_low_width", 32'(low_cnt), WR_LOW_CYC);
        got_q.push_back({dcx, data_out});
        rise_t.push_back(cyc);
        low_cnt = 0;
      end
      if (csx && !prev_csx) cs_rise++;
      prev_wrx = wrx;
      prev_csx = csx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic l, input logic d, input logic [15:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_last  = l;
    in_dc    = d;
    in_data  = w;
    while (!in_ready && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check_eq("push_timeout", 32'(in_ready), 32'd1);
    tick();
    exp_q.push_back({l, d, w});
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic drain_check();
    logic [17:0] e;
    logic [16:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check_eq("word_missing", 32'(e[16:0]), 32'h1ffff);
      end else begin
        g = got_q.pop_front();
        check_eq("word", 32'(g), 32'(e[16:0]));
      end
    end
    if (got_q.size() != 0) check_eq("word_extra", 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask

  // Measures lcd_reset low time and the post-reset wait; an init pulse is
  // offered mid-wait and must be ignored.
  task automatic power_seq(input string tag);
    int n;
    int cl0;
    cl0 = cs_low_cnt;
    n = 0;
    while (!lcd_reset && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_rst_low_cycles"}, 32'(n), RST_LOW_CYC);
    n = 0;
    while (busy && n < 100) begin
      if (n == 5) init_start = 1'b1;
      tick();
      init_start = 1'b0;
      n++;
    end
    check_eq({tag, "_rst_wait_cycles"}, 32'(n), RST_WAIT_CYC);
    check_eq({tag, "_csx_low_samples"}, 32'(cs_low_cnt - cl0), 32'd0);
  endtask

  initial begin
    int n;
    int cr0;
    int len;
    int bad;

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_dc      = 1'b0;
    in_last    = 1'b0;
    in_data    = '0;
    init_start = 1'b0;
    repeat (3) tick();

    check_eq("rst_csx",        32'(csx),        32'd1);
    check_eq("rst_dcx",        32'(dcx),        32'd1);
    check_eq("rst_wrx",        32'(wrx),        32'd1);
    check_eq("rst_rdx",        32'(rdx),        32'd1);
    check_eq("rst_lcd_reset",  32'(lcd_reset),  32'd0);
    check_eq("rst_data_out",   32'(data_out),   32'd0);
    check_eq("rst_busy",       32'(busy),       32'd1);
    check_eq("rst_fifo_level", 32'(fifo_level), 32'd0);
    check_eq("rst_in_ready",   32'(in_ready),   32'd1);

    reset_n = 1'b1;
    power_seq("pwr");

    // Single command
    cr0 = cs_rise;
    rise_t.delete();
    push_word(1'b1, 1'b0, 16'h002C);
    n = 0;
    while (wrx && n < 20) begin
      tick();
      n++;
    end
    check_eq("first_word_latency", 32'(n), 32'd2);
    wait_idle();
    check_eq("single_pulses", 32'(rise_t.size()), 32'd1);
    check_eq("single_cs_release", 32'(cs_rise - cr0), 32'd1);
    check_eq("single_csx_idle", 32'(csx), 32'd1);
    drain_check();

    // Back-to-back burst: command then four data words
    cr0 = cs_rise;
    rise_t.delete();
    push_word(1'b0, 1'b0, 16'h002C);
    for (int i = 0; i < 4; i++) push_word(i == 3, 1'b1, 16'(16'hA000 + i));
    wait_idle();
    check_eq("burst_pulses", 32'(rise_t.size()), 32'd5);
    for (int i = 1; i < rise_t.size(); i++) begin
      check_eq("burst_spacing", 32'(rise_t[i] - rise_t[i-1]), WR_LOW_CYC + WR_HIGH_CYC);
    end
    check_eq("burst_cs_release", 32'(cs_rise - cr0), 32'd1);
    drain_check();

    // Underrun: hold with csx low, resume on the next word
    cr0 = cs_rise;
    push_word(1'b0, 1'b1, 16'($urandom));
    n = 0;
    while (got_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (!(csx == 1'b0 && wrx == 1'b1)) bad++;
    end
    check_eq("hold_bus_stable", 32'(bad), 32'd0);
    push_word(1'b1, 1'b1, 16'($urandom));
    n = 0;
    while (wrx && n < 20) begin
      tick();
      n++;
    end
    check_eq("hold_resume_latency", 32'(n), 32'd1);
    wait_idle();
    check_eq("hold_cs_release", 32'(cs_rise - cr0), 32'd1);
    drain_check();

    // init_start mid-burst is ignored
    for (int i = 0; i < 4; i++) push_word(i == 3, 1'($urandom), 16'($urandom));
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    check_eq("init_busy_ignored", 32'(lcd_reset), 32'd1);
    wait_idle();
    drain_check();

    // init_start in IDLE reruns the reset sequence
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    check_eq("init_idle_lcd_reset", 32'(lcd_reset), 32'd0);
    check_eq("init_idle_busy", 32'(busy), 32'd1);
    power_seq("init");

    // Randomized bursts with random inter-word gaps
    for (int b = 0; b < 8; b++) begin
      cr0 = cs_rise;
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        if (i > 0) repeat ($urandom_range(0, 5)) tick();
        push_word(i == len - 1, 1'($urandom), 16'($urandom));
      end
      wait_idle();
      check_eq("rand_cs_release", 32'(cs_rise - cr0), 32'd1);
      drain_check();
    end

    // Fill the FIFO during the reset wait
    reset_n = 1'b0;
    tick();
    exp_q.delete();
    got_q.delete();
    reset_n = 1'b1;
    n = 0;
    while (!lcd_reset && n < 100) begin
      tick();
      n++;
    end
    for (int i = 0; i < 16; i++) push_word(1'($urandom), 1'($urandom), 16'($urandom));
    check_eq("full_level", 32'(fifo_level), 32'd16);
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    check_eq("full_no_pop_in_wait", 32'(got_q.size()), 32'd0);
    push_word(1'b1, 1'($urandom), 16'($urandom));
    wait_idle();
    check_eq("full_word_count", 32'(got_q.size()), 32'd17);
    drain_check();

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) push_word(i == 5, 1'b1, 16'($urandom_range(1, 16'hffff)));
    n = 0;
    while (got_q.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_csx",        32'(csx),        32'd1);
    check_eq("mid_rst_wrx",        32'(wrx),        32'd1);
    check_eq("mid_rst_dcx",        32'(dcx),        32'd1);
    check_eq("mid_rst_data_out",   32'(data_out),   32'd0);
    check_eq("mid_rst_lcd_reset",  32'(lcd_reset),  32'd0);
    check_eq("mid_rst_fifo_level", 32'(fifo_level), 32'd0);
    check_eq("mid_rst_in_ready",   32'(in_ready),   32'd1);
    exp_q.delete();
    got_q.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    power_seq("rerst");
    push_word(1'b1, 1'b0, 16'h0029);
    wait_idle();
    drain_check();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
